// File: rtl/sequenciador.sv
// Operation sequencer for the datapath controller: CLEARLD, ADDLD, a run of ADD steps,
// a run of SHIFTR steps, then DISPLAY until the consumer acknowledges.
module sequenciador (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] nadd,
  input  logic [1:0] nshift,
  input  logic       ack,
  input  logic       abort,
  output logic [2:0] Op,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] OpClearLd = 3'b000;
  localparam logic [2:0] OpAddLd   = 3'b001;
  localparam logic [2:0] OpAdd     = 3'b010;
  localparam logic [2:0] OpShiftR  = 3'b011;
  localparam logic [2:0] OpDisplay = 3'b100;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StClr  = 3'd1,
    StLda  = 3'd2,
    StAdds = 3'd3,
    StShr  = 3'd4,
    StDisp = 3'd5
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] add_cnt_q, add_cnt_d;
  logic [1:0] shift_cnt_q, shift_cnt_d;
  logic [2:0] op_d;
  logic       busy_d, done_d;

  always_comb begin
    state_d     = state_q;
    add_cnt_d   = add_cnt_q;
    shift_cnt_d = shift_cnt_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StClr;
          add_cnt_d   = nadd;
          shift_cnt_d = nshift;
        end
      end
      StClr: begin
        state_d = abort ? StIdle : StLda;
      end
      StLda: begin
        if (abort)                    state_d = StIdle;
        else if (add_cnt_q != 3'd0)   state_d = StAdds;
        else if (shift_cnt_q != 2'd0) state_d = StShr;
        else                          state_d = StDisp;
      end
      StAdds: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          // Count held on entry equals the number of ADD cycles; leave on the last one.
          if (add_cnt_q != 3'd0) add_cnt_d = add_cnt_q - 3'd1;
          if (add_cnt_q <= 3'd1) state_d = (shift_cnt_q != 2'd0) ? StShr : StDisp;
        end
      end
      StShr: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          if (shift_cnt_q != 2'd0) shift_cnt_d = shift_cnt_q - 2'd1;
          if (shift_cnt_q <= 2'd1) state_d = StDisp;
        end
      end
      StDisp: begin
        if (ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abandoned or finished sequences never leave stale counts behind.
    if (state_d == StIdle) begin
      add_cnt_d   = 3'd0;
      shift_cnt_d = 2'd0;
    end
  end

  // Outputs are decoded from the next state so the registered copies track the state register.
  always_comb begin
    op_d   = OpDisplay;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      StClr:  begin op_d = OpClearLd; busy_d = 1'b1; end
      StLda:  begin op_d = OpAddLd;   busy_d = 1'b1; end
      StAdds: begin op_d = OpAdd;     busy_d = 1'b1; end
      StShr:  begin op_d = OpShiftR;  busy_d = 1'b1; end
      StDisp: begin op_d = OpDisplay; done_d = 1'b1; end
      default: begin
        op_d   = OpDisplay;
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= StIdle;
      add_cnt_q   <= 3'd0;
      shift_cnt_q <= 2'd0;
      Op          <= OpDisplay;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      add_cnt_q   <= add_cnt_d;
      shift_cnt_q <= shift_cnt_d;
      Op          <= op_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

endmodule

// File: tb/tb_sequenciador.sv
// Self-checking bench for sequenciador: vector table, hand-written corner sequences and
// randomized traffic against a queue-based model of the expected Op stream.
module tb_sequenciador;

  logic       clock = 1'b0;
  logic       reset, start, ack, abort;
  logic [2:0] nadd;
  logic [1:0] nshift;
  logic [2:0] Op;
  logic       busy, done;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  sequenciador dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .nadd   (nadd),
    .nshift (nshift),
    .ack    (ack),
    .abort  (abort),
    .Op     (Op),
    .busy   (busy),
    .done   (done)
  );

  // Model: queue of Op values still to be shown while busy, plus a displaying flag.
  logic [2:0] mq[$];
  bit         m_disp = 1'b0;

  task automatic model_edge();
    logic [2:0] tmp;
    if (!reset) begin
      mq.delete();
      m_disp = 1'b0;
    end else if (mq.size() > 0) begin
      if (abort) begin
        mq.delete();
      end else begin
        tmp = mq.pop_front();
        if (mq.size() == 0) m_disp = 1'b1;
      end
    end else if (m_disp) begin
      if (ack) m_disp = 1'b0;
    end else if (start) begin
      mq.push_back(3'b000);
      mq.push_back(3'b001);
      for (int i = 0; i < int'(nadd); i++) mq.push_back(3'b010);
      for (int i = 0; i < int'(nshift); i++) mq.push_back(3'b011);
    end
  endtask

  task automatic check(input string name, input logic [2:0] eop, input logic ebusy,
                       input logic edone);
    tests++;
    if (Op !== eop || busy !== ebusy || done !== edone) begin
      fails++;
      $display("FAIL %s: got Op=%b busy=%b done=%b, expected Op=%b busy=%b done=%b",
               name, Op, busy, done, eop, ebusy, edone);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Advance one clock edge and compare against the model.
  task automatic step(input string name);
    model_edge();
    @(posedge clock);
    #1;
    if (mq.size() > 0) check(name, mq[0], 1'b1, 1'b0);
    else if (m_disp)   check(name, 3'b100, 1'b0, 1'b1);
    else               check(name, 3'b100, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic [2:0] nadd;
    logic [1:0] nshift;
    int         exp_done;
    int         exp_adds;
    int         exp_shifts;
    int         exp_busy;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int cyc, adds, shs, busyc, saw_done;

    tbl[0] = '{3'd1, 2'd1, 5, 1, 1, 4};
    tbl[1] = '{3'd0, 2'd0, 3, 0, 0, 2};
    tbl[2] = '{3'd7, 2'd3, 13, 7, 3, 12};
    tbl[3] = '{3'd0, 2'd2, 5, 0, 2, 4};
    tbl[4] = '{3'd3, 2'd0, 6, 3, 0, 5};
    tbl[5] = '{3'd2, 2'd1, 6, 2, 1, 5};

    reset = 1'b0; start = 1'b1; ack = 1'b0; abort = 1'b0; nadd = 3'd5; nshift = 2'd2;
    step("reset");
    check("reset_values", 3'b100, 1'b0, 1'b0);
    reset = 1'b1; start = 1'b0;
    step("idle");

    for (int v = 0; v < 6; v++) begin
      nadd = tbl[v].nadd; nshift = tbl[v].nshift; start = 1'b1;
      step("tbl_start");
      start = 1'b0; nadd = ~nadd; nshift = ~nshift;
      cyc = 1; adds = 0; shs = 0; busyc = 0;
      while (!done && cyc <= 20) begin
        if (busy) busyc++;
        if (Op == 3'b010) adds++;
        if (Op == 3'b011) shs++;
        step("tbl_run");
        cyc++;
      end
      check_int("tbl_done_cycle", cyc, tbl[v].exp_done);
      check_int("tbl_add_cycles", adds, tbl[v].exp_adds);
      check_int("tbl_shift_cycles", shs, tbl[v].exp_shifts);
      check_int("tbl_busy_cycles", busyc, tbl[v].exp_busy);
      step("tbl_hold");
      ack = 1'b1;
      step("tbl_ack");
      ack = 1'b0;
    end

    // Abort in the second ADD cycle while start is held high.
    nadd = 3'd3; nshift = 2'd1; start = 1'b1;
    step("abort_clr");
    step("abort_lda");
    step("abort_add1");
    step("abort_add2");
    check("abort_in_add2", 3'b010, 1'b1, 1'b0);
    abort = 1'b1; start = 1'b0;
    step("abort_edge");
    abort = 1'b0;
    check("abort_idle", 3'b100, 1'b0, 1'b0);
    saw_done = 0;
    repeat (4) begin
      step("abort_quiet");
      if (done) saw_done = 1;
    end
    check_int("abort_no_done", saw_done, 0);

    // Reset in the middle of SHR, with every other control asserted.
    nadd = 3'd0; nshift = 2'd3; start = 1'b1;
    step("rst_clr");
    start = 1'b0;
    step("rst_lda");
    step("rst_shr1");
    check("rst_in_shr", 3'b011, 1'b1, 1'b0);
    reset = 1'b0; ack = 1'b1; abort = 1'b1; start = 1'b1;
    step("rst_mid");
    check("rst_values_mid", 3'b100, 1'b0, 1'b0);
    reset = 1'b1; ack = 1'b0; abort = 1'b0; start = 1'b0;
    repeat (3) step("rst_after");
    check("rst_needs_start", 3'b100, 1'b0, 1'b0);

    // Abort ignored in DISP; ack wins when both are high.
    nadd = 3'd0; nshift = 2'd0; start = 1'b1;
    step("disp_clr");
    start = 1'b0;
    step("disp_lda");
    step("disp_enter");
    check("disp_hold", 3'b100, 1'b0, 1'b1);
    abort = 1'b1;
    step("disp_abort");
    check("disp_abort_ignored", 3'b100, 1'b0, 1'b1);
    ack = 1'b1;
    step("disp_ack_abort");
    check("ack_over_abort", 3'b100, 1'b0, 1'b0);
    ack = 1'b0; abort = 1'b0;

    // Randomized traffic, including count changes mid-sequence.
    for (int i = 0; i < 600; i++) begin
      reset  = ($urandom_range(0, 59) != 0);
      start  = ($urandom_range(0, 2) == 0);
      abort  = ($urandom_range(0, 19) == 0);
      ack    = ($urandom_range(0, 3) == 0);
      nadd   = 3'($urandom_range(0, 7));
      nshift = 2'($urandom_range(0, 3));
      step("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sequenciador.md
SEQUENCIADOR -- requirements
Module: sequenciador

Interface
REQ-001 The block SHALL have the port `clock`, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-002 The block SHALL have the port `reset`, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of `clock`.
REQ-003 The block SHALL have the port `start`, input, 1 bit: request to run one operation sequence; sampled only in IDLE.
REQ-004 The block SHALL have the port `nadd`, input, 3 bits: number of ADD steps, 0..7; latched on an accepted `start`.
REQ-005 The block SHALL have the port `nshift`, input, 2 bits: number of SHIFTR steps, 0..3; latched on an accepted `start`.
REQ-006 The block SHALL have the port `ack`, input, 1 bit: consumer acknowledgement of the displayed result.
REQ-007 The block SHALL have the port `abort`, input, 1 bit: cancels the sequence in progress.
REQ-008 The block SHALL have the port `Op`, output, 3 bits: datapath control opcode (000 CLEARLD, 001 ADDLD, 010 ADD, 011 SHIFTR, 100 DISPLAY), driven to the `Op` input of the datapath controller.
REQ-009 The block SHALL have the port `busy`, output, 1 bit: high while a sequence is executing.
REQ-010 The block SHALL have the port `done`, output, 1 bit: high while a finished result is held on display, awaiting `ack`.

Function
REQ-011 The block SHALL implement a Moore FSM with the states IDLE, CLR, LDA, ADDS, SHR and DISP; `Op`, `busy` and `done` SHALL be registered and SHALL be functions of state only.
REQ-012 In IDLE, outputs SHALL be `Op`=100, `busy`=0, `done`=0.
REQ-013 In IDLE with `start`=1, the next state SHALL be CLR; `nadd` and `nshift` SHALL be latched into internal counters on the same edge.
REQ-014 CLR SHALL last exactly 1 cycle with `Op`=000, then go to LDA.
REQ-015 LDA SHALL last exactly 1 cycle with `Op`=001, then go to ADDS if latched `nadd`>0, else to SHR if latched `nshift`>0, else to DISP.
REQ-016 ADDS SHALL hold `Op`=010 for exactly latched-`nadd` cycles, using a down-counter, then go to SHR if latched `nshift`>0, else to DISP.
REQ-017 SHR SHALL hold `Op`=011 for exactly latched-`nshift` cycles, then go to DISP.
REQ-018 `busy` SHALL be 1 in CLR, LDA, ADDS and SHR, and 0 otherwise.
REQ-019 DISP SHALL output `Op`=100, `busy`=0, `done`=1, and SHALL remain in DISP until `ack`=1, then go to IDLE on that edge.
REQ-020 Latency SHALL be as follows: with `start` accepted at edge k, `done` SHALL first be 1 after edge k+3+nadd+nshift (counting CLR at k+1).
REQ-021 `start` SHALL be ignored in every state except IDLE; changes to `nadd`/`nshift` after acceptance SHALL NOT affect the running sequence.
REQ-022 `abort`=1 in CLR, LDA, ADDS or SHR SHALL force the next state to IDLE without passing through DISP; `abort` SHALL be ignored in IDLE and DISP.
REQ-023 If `abort` and `ack` are both 1 in DISP, `ack` SHALL take effect (next state IDLE).
REQ-024 Counters SHALL NOT wrap: the decrement SHALL stop at 0, and a count of 0 SHALL skip the phase entirely (no zero-length Op pulse).
REQ-025 Any unused state encoding SHALL go to IDLE on the next edge.

Reset
REQ-026 `reset`=0 at a rising edge SHALL force state IDLE, `Op`=100, `busy`=0, `done`=0, and both counters to 0, regardless of the current state or other inputs.
REQ-027 Reset asserted mid-sequence SHALL discard the latched counts; after reset is released, a new `start` SHALL be required.
REQ-028 `reset` SHALL take priority over `start`, `abort` and `ack`.

Verification
REQ-029 Scenario 1: `start`=1 for one cycle with nadd=1, nshift=1 -> `Op` sequence 000,001,010,011,100; `busy`=1 for 4 cycles; `done`=1 from cycle 5 until `ack`.
REQ-030 Scenario 2: nadd=0, nshift=0 -> `Op` 000,001,100; `done` at cycle 3; no 010 or 011 appears.
REQ-031 Scenario 3: nadd=7, nshift=3 -> exactly 7 cycles of 010 followed by exactly 3 cycles of 011; `done` at cycle 13.
REQ-032 Scenario 4: `abort`=1 during the 2nd ADD cycle -> IDLE next cycle, `Op`=100, `busy`=0, `done` never asserted; `start` held high while busy is ignored.
REQ-033 Scenario 5: `reset`=0 during SHR -> all outputs at reset values the next cycle; `ack`=1 held in DISP with `abort`=1 -> IDLE.
